// File: rtl/multi128_sched.sv
// Round-robin front end that shares one pipelined multiplier among NUM_REQ requesters.
// Tags ride alongside the multiplier so each product returns with its requester ID.
`timescale 1ns/1ps
module multi128_sched #(
  parameter int DATA_WIDTH  = 128,
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              issue_en,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_dat1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_dat2,
  output logic [DATA_WIDTH-1:0]             mul_dat1,
  output logic [DATA_WIDTH-1:0]             mul_dat2,
  input  logic [2*DATA_WIDTH-1:0]           mul_product,
  output logic                              rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]        rsp_id,
  output logic [2*DATA_WIDTH-1:0]           rsp_product,
  output logic [$clog2(MUL_LATENCY+2)-1:0]  inflight,
  output logic                              idle
);

  localparam int ID_WIDTH = $clog2(NUM_REQ);
  localparam int LAST     = MUL_LATENCY;

  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] grant_idx;
  logic [ID_WIDTH-1:0] next_ptr;
  logic                grant_any;
  logic                xfer;
  int                  idx;

  logic [MUL_LATENCY:0] tag_vld;
  logic [ID_WIDTH-1:0]  tag_id [MUL_LATENCY+1];

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = ID_WIDTH'(idx);
      end
    end
  end

  // Ready is held low during reset so no transfer can be recorded while state is cleared.
  assign xfer     = rst_n & issue_en & grant_any;
  assign next_ptr = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[grant_idx] = 1'b1;
  end

  // Issue stage: operands hold when nothing is granted so the multiplier inputs stay quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      mul_dat1 <= '0;
      mul_dat2 <= '0;
    end else if (xfer) begin
      rr_ptr   <= next_ptr;
      mul_dat1 <= req_dat1[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
      mul_dat2 <= req_dat2[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Tag pipeline: stage LAST lines up with the product on mul_product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tag_vld <= '0;
    else        tag_vld <= {tag_vld[MUL_LATENCY-1:0], xfer};
  end

  always_ff @(posedge clk) begin
    tag_id[0] <= grant_idx;
    for (int k = 1; k <= LAST; k++) tag_id[k] <= tag_id[k-1];
  end

  // Response stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
    end else begin
      rsp_valid <= tag_vld[LAST];
      if (tag_vld[LAST]) begin
        rsp_id      <= tag_id[LAST];
        rsp_product <= mul_product;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({xfer, tag_vld[LAST]})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  assign idle = (inflight == '0) && !rsp_valid;

endmodule

// File: tb/tb_multi128_sched.sv
// Bench for multi128_sched: behavioural scheduler model checked every cycle,
// plus directed scenarios with hand-computed grant orders and products.
`timescale 1ns/1ps
module tb_multi128_sched;

  localparam int DW  = 128;
  localparam int NR  = 4;
  localparam int ML  = 2;
  localparam int IDW = 2;
  localparam int CW  = 2;

  logic              clk;
  logic              rst_n;
  logic              issue_en;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_dat1;
  logic [NR*DW-1:0]  req_dat2;
  logic [DW-1:0]     mul_dat1;
  logic [DW-1:0]     mul_dat2;
  logic [2*DW-1:0]   mul_product;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [2*DW-1:0]   rsp_product;
  logic [CW-1:0]     inflight;
  logic              idle;

  multi128_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MUL_LATENCY(ML)) dut (
    .clk(clk), .rst_n(rst_n), .issue_en(issue_en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dat1(req_dat1), .req_dat2(req_dat2),
    .mul_dat1(mul_dat1), .mul_dat2(mul_dat2), .mul_product(mul_product),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_product(rsp_product),
    .inflight(inflight), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the pipelined multiplier: ML register stages, reset with the scheduler.
  logic [2*DW-1:0] mp [ML];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ML; k++) mp[k] <= '0;
    end else begin
      mp[0] <= 256'(mul_dat1) * 256'(mul_dat2);
      for (int k = 1; k < ML; k++) mp[k] <= mp[k-1];
    end
  end
  assign mul_product = mp[ML-1];

  int errors;
  int checks;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  typedef struct { int due; int id; logic [255:0] prod; } op_t;
  typedef struct { int cyc; int id; logic [255:0] prod; } ev_t;

  op_t mq[$];
  ev_t grant_log[$];
  ev_t rsp_log[$];

  int              cyc;
  int              m_ptr;
  int              m_g;
  int              m_idx;
  logic [IDW-1:0]  m_last_id;
  logic [255:0]    m_last_prod;
  logic [DW-1:0]   m_mul1;
  logic [DW-1:0]   m_mul2;
  logic            m_exp_v;
  logic [NR-1:0]   m_ready;
  op_t             m_op;
  ev_t             m_ev;

  // Model: pending operations as a queue of (due cycle, id, product); grant = first
  // valid requester at or after the pointer, cyclically.
  initial begin
    cyc = 0;
    m_ptr = 0;
    m_last_id = '0;
    m_last_prod = '0;
    m_mul1 = '0;
    m_mul2 = '0;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        mq.delete();
        m_ptr = 0;
        m_last_id = '0;
        m_last_prod = '0;
        m_mul1 = '0;
        m_mul2 = '0;
        chk("rst_req_ready", 256'(req_ready), 256'(0));
        chk("rst_rsp_valid", 256'(rsp_valid), 256'(0));
        chk("rst_rsp_id", 256'(rsp_id), 256'(0));
        chk("rst_rsp_product", rsp_product, 256'(0));
        chk("rst_inflight", 256'(inflight), 256'(0));
        chk("rst_idle", 256'(idle), 256'(1));
        chk("rst_mul_dat1", 256'(mul_dat1), 256'(0));
        chk("rst_mul_dat2", 256'(mul_dat2), 256'(0));
      end else begin
        m_exp_v = 1'b0;
        if (mq.size() > 0 && mq[0].due == cyc) begin
          m_exp_v = 1'b1;
          m_last_id = IDW'(mq[0].id);
          m_last_prod = mq[0].prod;
          void'(mq.pop_front());
        end
        chk("rsp_valid", 256'(rsp_valid), 256'(m_exp_v));
        chk("rsp_id", 256'(rsp_id), 256'(m_last_id));
        chk("rsp_product", rsp_product, m_last_prod);
        chk("inflight", 256'(inflight), 256'(mq.size()));
        chk("idle", 256'(idle), 256'(mq.size() == 0 && !m_exp_v));
        chk("mul_dat1", 256'(mul_dat1), 256'(m_mul1));
        chk("mul_dat2", 256'(mul_dat2), 256'(m_mul2));

        m_g = -1;
        if (issue_en) begin
          for (int k = 0; k < NR; k++) begin
            m_idx = (m_ptr + k) % NR;
            if (m_g < 0 && req_valid[m_idx]) m_g = m_idx;
          end
        end
        m_ready = '0;
        if (m_g >= 0) m_ready[m_g] = 1'b1;
        chk("req_ready", 256'(req_ready), 256'(m_ready));

        if (m_g >= 0) begin
          m_mul1 = req_dat1[m_g*DW +: DW];
          m_mul2 = req_dat2[m_g*DW +: DW];
          m_op.due = cyc + ML + 2;
          m_op.id = m_g;
          m_op.prod = 256'(m_mul1) * 256'(m_mul2);
          mq.push_back(m_op);
          m_ptr = (m_g + 1) % NR;
        end

        if (rsp_valid) begin
          m_ev.cyc = cyc;
          m_ev.id = int'(rsp_id);
          m_ev.prod = rsp_product;
          rsp_log.push_back(m_ev);
        end
        for (int k = 0; k < NR; k++) begin
          if (req_valid[k] && req_ready[k]) begin
            m_ev.cyc = cyc;
            m_ev.id = k;
            m_ev.prod = '0;
            grant_log.push_back(m_ev);
          end
        end
      end
      cyc++;
    end
  end

  task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_dat1[i*DW +: DW] = a;
    req_dat2[i*DW +: DW] = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_logs();
    grant_log.delete();
    rsp_log.delete();
  endtask

  int cont_ids  [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int cont_prod [4] = '{10, 22, 36, 52};
  int fair_ids  [4] = '{1, 3, 1, 3};
  int peak;
  logic [255:0] max_prod;

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    issue_en = 1'b1;
    req_valid = '0;
    req_dat1 = '0;
    req_dat2 = '0;
    max_prod = {128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, 128'h1};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #4;
    chk("reset_req_ready", 256'(req_ready), 256'(0));
    chk("reset_rsp_valid", 256'(rsp_valid), 256'(0));
    chk("reset_inflight", 256'(inflight), 256'(0));
    chk("reset_idle", 256'(idle), 256'(1));
    chk("reset_mul_dat1", 256'(mul_dat1), 256'(0));
    chk("reset_mul_dat2", 256'(mul_dat2), 256'(0));

    // Single operation from requester 2: 3*5
    @(negedge clk);
    clear_logs();
    set_op(2, 128'd3, 128'd5);
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    repeat (6) @(negedge clk);
    chk("single_grant_count", 256'(grant_log.size()), 256'(1));
    chk("single_rsp_count", 256'(rsp_log.size()), 256'(1));
    if (grant_log.size() == 1 && rsp_log.size() == 1) begin
      chk("single_rsp_id", 256'(rsp_log[0].id), 256'(2));
      chk("single_rsp_product", rsp_log[0].prod, 256'(15));
      // rsp appears in the cycle three edges after the accepting edge
      chk("single_latency", 256'(rsp_log[0].cyc - grant_log[0].cyc), 256'(4));
    end

    // Largest operands
    @(negedge clk);
    clear_logs();
    set_op(2, '1, '1);
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    repeat (6) @(negedge clk);
    chk("max_rsp_count", 256'(rsp_log.size()), 256'(1));
    if (rsp_log.size() == 1) chk("max_rsp_product", rsp_log[0].prod, max_prod);

    // Full contention from a fresh pointer
    do_reset();
    @(negedge clk);
    clear_logs();
    for (int i = 0; i < NR; i++) set_op(i, 128'(i + 1), 128'(i + 10));
    req_valid = '1;
    peak = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #4;
      if (int'(inflight) > peak) peak = int'(inflight);
    end
    @(negedge clk);
    req_valid = '0;
    repeat (6) @(negedge clk);
    chk("cont_grant_count", 256'(grant_log.size()), 256'(8));
    chk("cont_rsp_count", 256'(rsp_log.size()), 256'(8));
    chk("cont_inflight_peak", 256'(peak), 256'(3));
    for (int k = 0; k < 8; k++) begin
      if (k < grant_log.size()) chk("cont_grant_id", 256'(grant_log[k].id), 256'(cont_ids[k]));
      if (k < rsp_log.size()) begin
        chk("cont_rsp_id", 256'(rsp_log[k].id), 256'(cont_ids[k]));
        chk("cont_rsp_product", rsp_log[k].prod, 256'(cont_prod[cont_ids[k]]));
        chk("cont_rsp_back_to_back", 256'(rsp_log[k].cyc - rsp_log[0].cyc), 256'(k));
      end
    end

    // Pointer fairness with requesters 1 and 3
    do_reset();
    @(negedge clk);
    clear_logs();
    set_op(1, 128'd6, 128'd7);
    set_op(3, 128'd8, 128'd9);
    req_valid = 4'b1010;
    repeat (4) @(negedge clk);
    req_valid = '0;
    repeat (6) @(negedge clk);
    chk("fair_grant_count", 256'(grant_log.size()), 256'(4));
    for (int k = 0; k < 4; k++)
      if (k < grant_log.size()) chk("fair_grant_id", 256'(grant_log[k].id), 256'(fair_ids[k]));

    // issue_en drain
    @(negedge clk);
    clear_logs();
    set_op(0, 128'd7, 128'd9);
    req_valid = 4'b0001;
    repeat (2) @(negedge clk);
    issue_en = 1'b0;
    #4;
    chk("drain_ready_gated", 256'(req_ready), 256'(0));
    repeat (7) @(negedge clk);
    #4;
    chk("drain_grant_count", 256'(grant_log.size()), 256'(2));
    chk("drain_rsp_count", 256'(rsp_log.size()), 256'(2));
    chk("drain_inflight", 256'(inflight), 256'(0));
    chk("drain_idle", 256'(idle), 256'(1));
    @(negedge clk);
    req_valid = '0;
    issue_en = 1'b1;

    // Reset one cycle after an issue
    @(negedge clk);
    clear_logs();
    set_op(1, 128'd11, 128'd13);
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_grant_count", 256'(grant_log.size()), 256'(1));
    chk("midrst_no_rsp", 256'(rsp_log.size()), 256'(0));
    @(negedge clk);
    clear_logs();
    set_op(0, 128'd2, 128'd3);
    set_op(2, 128'd4, 128'd5);
    req_valid = 4'b0101;
    @(negedge clk);
    req_valid = '0;
    repeat (6) @(negedge clk);
    chk("midrst_grant_after", 256'(grant_log.size()), 256'(1));
    if (grant_log.size() == 1) chk("midrst_ptr_restart", 256'(grant_log[0].id), 256'(0));

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multi128_sched.md
# multi128_sched

Round-robin scheduler sharing one pipelined `multi128` Karatsuba multiplier among `NUM_REQ` requesters. It accepts at most one operand pair per cycle through per-requester valid/ready handshakes and drives the operands into the multiplier. A tag pipeline matched to the multiplier latency tracks every issued operation. Each product is returned on a shared, registered response bus tagged with the originating requester ID.

## Interface
- `DATA_WIDTH`, 128: operand width; products are `2*DATA_WIDTH`.
- `NUM_REQ`, 4: number of requesters; legal range 2..16.
- `MUL_LATENCY`, 2: cycles from operands present on `mul_dat1`/`mul_dat2` to the matching `mul_product`; must be ≥1.
- `ID_WIDTH` (localparam) = `$clog2(NUM_REQ)`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `issue_en`  in  1  when low, no new grants; in-flight operations drain normally.
- `req_valid`  in  NUM_REQ  per-requester operand-pair valid.
- `req_ready`  out  NUM_REQ  one-hot-or-zero grant.
- `req_dat1`  in  NUM_REQ*DATA_WIDTH  packed operand A; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- `req_dat2`  in  NUM_REQ*DATA_WIDTH  packed operand B, same packing.
- `mul_dat1`, `mul_dat2`  out  DATA_WIDTH each  registered operands to the multiplier.
- `mul_product`  in  2*DATA_WIDTH  product from the multiplier.
- `rsp_valid`  out  1  registered response valid.
- `rsp_id`  out  ID_WIDTH  requester that owns `rsp_product`.
- `rsp_product`  out  2*DATA_WIDTH  registered product.
- `inflight`  out  $clog2(MUL_LATENCY+2)  count of issued-but-unreturned operations.
- `idle`  out  1  high when `inflight`==0 and `rsp_valid`==0.

## Operation
- **Arbitration**
  - Combinational round-robin over `req_valid`, starting the search at pointer `rr_ptr`.
  - `req_ready[i]` is high only for the winning requester, and only when `issue_en`=1.
  - `req_ready` depends combinationally on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- **Handshake:** a transfer occurs on a rising edge where `req_valid[i] & req_ready[i]`. Requesters must hold the operand pair stable while valid and not yet accepted.
- **Pointer update:** on a transfer from requester i, `rr_ptr` ← (i+1) mod NUM_REQ. With no transfer, `rr_ptr` holds. This gives starvation freedom: with all requesters valid, grants rotate 0,1,2,3,0,…
- **Issue**
  - On a transfer, the operand slices of the winner are registered into `mul_dat1`/`mul_dat2`, and a tag {1, i} enters stage 0 of a MUL_LATENCY+1 deep tag shift register.
  - With no transfer, `mul_dat*` hold their previous value (no toggling) and a tag {0, x} enters stage 0.
- **Return:** when the last tag stage is valid, `rsp_valid`←1, `rsp_id`←tag id, `rsp_product`←`mul_product`; otherwise `rsp_valid`←0 and `rsp_id`/`rsp_product` hold.
- **No response backpressure:** a response is valid for exactly one cycle, and every requester must be able to capture it.
- **Ordering:** responses return in issue order.
- **In-flight counter:** `inflight` is incremented on issue and decremented when `rsp_valid` is set. On a simultaneous issue and return, the count is unchanged.
- **Reset**
  - All outputs go to 0: `req_ready`=0, `mul_dat*`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_product`=0, `inflight`=0.
  - `idle`=1; all tag stages are invalid; `rr_ptr`=0.
  - Reset mid-operation discards all in-flight tags. No response is produced for them, even though the multiplier pipeline also resets.

## Timing
- A transfer at edge E0 places operands on `mul_dat*` during cycle E0..E1.
- `mul_product` is valid MUL_LATENCY cycles later.
- `rsp_valid` is asserted in the cycle beginning at edge E0+MUL_LATENCY+1. With the default latency of 2, that is 3 cycles after the accepting edge.
- Throughput is one operation per cycle, sustained. There are no bubbles between back-to-back grants, including grants to the same requester when it is the only one valid.
- Deasserting `issue_en` takes effect the same cycle (combinational gating of `req_ready`). Operations already in flight still return at their scheduled cycles.
- `inflight` maximum is MUL_LATENCY+1.

## Test plan
- **Reset values:** apply reset, then release with all `req_valid`=0 → `req_ready`=0, `rsp_valid`=0, `inflight`=0, `idle`=1, `mul_dat*`=0.
- **Single operation:** requester 2 sends dat1=3, dat2=5 at edge E0 → `rsp_valid`=1 only during cycle E0+3, with `rsp_id`=2 and `rsp_product`=15. Also send dat1=dat2=2^128−1 → `rsp_product`=2^256−2^129+1.
- **Full contention:** all 4 requesters valid continuously for 8 cycles → grants 0,1,2,3,0,1,2,3. Responses arrive back-to-back with matching IDs; `inflight` peaks at 3.
- **Pointer fairness:** `rr_ptr`=0, only requesters 1 and 3 valid → grants alternate 1,3,1,3; requester 1 never receives two grants in a row.
- **issue_en drain:** drop `issue_en` after 2 consecutive issues → `req_ready`=0 that cycle, both responses still arrive, then `inflight` reaches 0 and `idle`=1.
- **Reset mid-flight:** assert `rst_n`=0 one cycle after an issue, then release → no `rsp_valid` pulse ever appears for that operation, and `rr_ptr` restarts at 0.
